qrs_rr_controller: RTL and testbench
====================================

QRS_RR_CONTROLLER -- requirements
Module: qrs_rr_controller

Interface
REQ-001 Parameter REFRACT, default 50: refractory length in samples after QRS end.
REQ-002 Parameter TACHY_RR, default 150: RR (samples) below which rate is tachycardic.
REQ-003 Parameter BRADY_RR, default 300: RR (samples) above which rate is bradycardic.
REQ-004 Parameter IRREG_DELTA, default 40: |RR - previous RR| above which a beat is irregular.
REQ-005 Parameter ASYS_LIMIT, default 1000: samples without QRS before asystole flag.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 en  input  1  detection enable.
REQ-009 sample_valid  input  1  one-clock strobe per new integrated sample.
REQ-010 integ_in  input  16 signed  integrated energy from the Pan-Tompkins datapath.
REQ-011 thr  input  16 signed  detection threshold, sampled on each sample_valid.
REQ-012 qrs_pulse  output  1  one-clock QRS detection strobe.
REQ-013 rr_valid  output  1  one-clock strobe, rr_interval updated.
REQ-014 rr_interval  output  16  last RR interval in samples, unsigned, saturating.
REQ-015 rhythm  output  2  00 normal, 01 brady, 10 tachy, 11 irregular/AF (LED encoding).
REQ-016 asystole  output  1  level, no QRS for ASYS_LIMIT samples.

Function
REQ-017 FSM states IDLE, SEARCH, PEAK, REFRACT; all transitions evaluated only on clocks with sample_valid=1, except en=0 handling.
REQ-018 en=0: next state IDLE; rr_cnt, ref_cnt, irr_cnt, have_prev, asystole cleared; rr_interval and rhythm hold.
REQ-019 IDLE -> SEARCH on first clock with en=1 (no sample_valid needed).
REQ-020 SEARCH -> PEAK on sample with integ_in > thr (signed compare, strictly greater): a "crossing".
REQ-021 PEAK -> REFRACT on sample with integ_in <= thr; ref_cnt loaded with 0.
REQ-022 REFRACT: ref_cnt increments per sample; -> SEARCH on the sample where ref_cnt reaches REFRACT-1; crossings in REFRACT ignored.
REQ-023 qrs_pulse = 1 for exactly the clock after a crossing sample; 0 otherwise.
REQ-024 rr_cnt: 16-bit, +1 per sample_valid, saturates at 0xFFFF, cleared to 0 on crossing sample.
REQ-025 On crossing with have_prev=1: rr_interval <= min(rr_cnt+1, 0xFFFF); rr_valid pulses with qrs_pulse.
REQ-026 First crossing after reset or en=0: qrs_pulse only, no rr_valid; sets have_prev.
REQ-027 Irregularity: on each rr_valid after the first, delta=|new RR - previous RR|; delta > IRREG_DELTA -> irr_cnt+1 (saturate 3), else irr_cnt=0.
REQ-028 rhythm updated same clock as rr_valid: irr_cnt (post-update)==3 -> 11; else RR<TACHY_RR -> 10; else RR>BRADY_RR -> 01; else 00.
REQ-029 asystole set when rr_cnt reaches ASYS_LIMIT in SEARCH/PEAK/REFRACT; cleared on next crossing (same clock as qrs_pulse).
REQ-030 Simultaneous en falling and crossing: en=0 wins, no qrs_pulse.
REQ-031 Arithmetic on RR values unsigned 16-bit with 17-bit intermediate for saturation and delta.

Reset
REQ-032 rst_n=0 at a rising edge: state IDLE, all counters 0, have_prev=0, qrs_pulse=0, rr_valid=0, rr_interval=0, rhythm=00, asystole=0.
REQ-033 Reset mid-PEAK or mid-REFRACT aborts; first crossing after release treated per REQ-026.

Verification
REQ-034 rst_n low 2 clocks, en=1 -> all outputs 0; FSM reaches SEARCH one clock after release.
REQ-035 thr=8000, integ_in 9000 for 5 samples every 200 samples, else 100 -> qrs_pulse per beat; rr_valid from 2nd beat, rr_interval=200, rhythm=00.
REQ-036 Same pulse train period 100 -> rr_interval=100, rhythm=10; period 400 -> rhythm=01.
REQ-037 Second 9000 burst 30 samples after first falling crossing -> no qrs_pulse, no rr_valid.
REQ-038 RRs 200,120,260,180 -> deltas 80,140,80, rhythm=11 at 4th rr_valid; then 200,200 -> irr_cnt=0, rhythm=00.
REQ-039 No crossing for 1000 samples -> asystole=1 at sample 1000; next crossing clears it with qrs_pulse; en dropped mid-REFRACT -> IDLE, rhythm held.

Source files
------------

// File: rtl/qrs_rr_controller.sv
// QRS detection FSM with RR-interval measurement, rhythm classification and asystole watch.
// Consumes one integrated Pan-Tompkins energy sample per sample_valid strobe.
module qrs_rr_controller #(
    parameter int REFRACT     = 50,
    parameter int TACHY_RR    = 150,
    parameter int BRADY_RR    = 300,
    parameter int IRREG_DELTA = 40,
    parameter int ASYS_LIMIT  = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sample_valid,
    input  logic signed [15:0] integ_in,
    input  logic signed [15:0] thr,
    output logic               qrs_pulse,
    output logic               rr_valid,
    output logic [15:0]        rr_interval,
    output logic [1:0]         rhythm,
    output logic               asystole
);

    localparam logic [16:0] REF_LAST = (REFRACT > 0) ? 17'(REFRACT - 1) : 17'd0;
    localparam logic [16:0] TACHY_C  = 17'(TACHY_RR);
    localparam logic [16:0] BRADY_C  = 17'(BRADY_RR);
    localparam logic [16:0] IRREG_C  = 17'(IRREG_DELTA);
    localparam logic [16:0] ASYS_C   = 17'(ASYS_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_PEAK,
        S_REFRACT
    } state_t;

    state_t      state_q;
    logic [15:0] rr_cnt_q;
    logic [15:0] ref_cnt_q;
    logic [15:0] rr_interval_q;
    logic [1:0]  irr_cnt_q;
    logic [1:0]  rhythm_q;
    logic        have_prev_q;
    logic        rr_seen_q;
    logic        qrs_pulse_q;
    logic        rr_valid_q;
    logic        asystole_q;

    logic        above;
    logic        crossing;
    logic [15:0] rr_cnt_inc_d;
    logic [15:0] ref_cnt_inc_d;
    logic [16:0] delta_d;
    logic [1:0]  irr_cnt_d;
    logic [1:0]  rhythm_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [16:0] s;
        s = {1'b0, v} + 17'd1;
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [16:0] abs_diff17(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[16] ? (17'd0 - d) : d;
    endfunction

    function automatic logic [1:0] classify(input logic [15:0] rr, input logic [1:0] irr);
        if (irr == 2'd3) begin
            return 2'b11;
        end else if ({1'b0, rr} < TACHY_C) begin
            return 2'b10;
        end else if ({1'b0, rr} > BRADY_C) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign above         = integ_in > thr;
    assign crossing      = en && sample_valid && (state_q == S_SEARCH) && above;
    assign rr_cnt_inc_d  = sat_inc16(rr_cnt_q);
    assign ref_cnt_inc_d = ref_cnt_q + 16'd1;
    // The new RR is rr_cnt+1 saturated; the previous RR is still held in rr_interval_q.
    assign delta_d       = abs_diff17(rr_cnt_inc_d, rr_interval_q);

    always_comb begin
        irr_cnt_d = irr_cnt_q;
        if (rr_seen_q) begin
            if (delta_d > IRREG_C) begin
                irr_cnt_d = (irr_cnt_q == 2'd3) ? 2'd3 : irr_cnt_q + 2'd1;
            end else begin
                irr_cnt_d = 2'd0;
            end
        end
    end

    assign rhythm_d = classify(rr_cnt_inc_d, irr_cnt_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_cnt_q      <= 16'd0;
            ref_cnt_q     <= 16'd0;
            rr_interval_q <= 16'd0;
            irr_cnt_q     <= 2'd0;
            rhythm_q      <= 2'b00;
            have_prev_q   <= 1'b0;
            rr_seen_q     <= 1'b0;
            qrs_pulse_q   <= 1'b0;
            rr_valid_q    <= 1'b0;
            asystole_q    <= 1'b0;
        end else begin
            qrs_pulse_q <= 1'b0;
            rr_valid_q  <= 1'b0;
            if (!en) begin
                // Disable wins over any simultaneous crossing; RR and rhythm stay visible.
                state_q     <= S_IDLE;
                rr_cnt_q    <= 16'd0;
                ref_cnt_q   <= 16'd0;
                irr_cnt_q   <= 2'd0;
                have_prev_q <= 1'b0;
                rr_seen_q   <= 1'b0;
                asystole_q  <= 1'b0;
            end else begin
                if (sample_valid) begin
                    rr_cnt_q <= crossing ? 16'd0 : rr_cnt_inc_d;
                    if (!crossing && (state_q != S_IDLE) && ({1'b0, rr_cnt_inc_d} >= ASYS_C)) begin
                        asystole_q <= 1'b1;
                    end
                end
                unique case (state_q)
                    S_IDLE: begin
                        state_q <= S_SEARCH;
                    end
                    S_SEARCH: begin
                        if (crossing) begin
                            state_q     <= S_PEAK;
                            qrs_pulse_q <= 1'b1;
                            asystole_q  <= 1'b0;
                            have_prev_q <= 1'b1;
                            if (have_prev_q) begin
                                rr_valid_q    <= 1'b1;
                                rr_interval_q <= rr_cnt_inc_d;
                                irr_cnt_q     <= irr_cnt_d;
                                rhythm_q      <= rhythm_d;
                                rr_seen_q     <= 1'b1;
                            end
                        end
                    end
                    S_PEAK: begin
                        if (sample_valid && !above) begin
                            state_q   <= S_REFRACT;
                            ref_cnt_q <= 16'd0;
                        end
                    end
                    S_REFRACT: begin
                        if (sample_valid) begin
                            ref_cnt_q <= ref_cnt_inc_d;
                            if ({1'b0, ref_cnt_inc_d} >= REF_LAST) begin
                                state_q <= S_SEARCH;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign qrs_pulse   = qrs_pulse_q;
    assign rr_valid    = rr_valid_q;
    assign rr_interval = rr_interval_q;
    assign rhythm      = rhythm_q;
    assign asystole    = asystole_q;

endmodule

// File: tb/tb_qrs_rr_controller.sv
// Self-checking bench for qrs_rr_controller: directed scenarios plus randomized beat trains
// compared against a sample-index based behavioural model.
module tb_qrs_rr_controller;

    localparam int REFRACT     = 50;
    localparam int TACHY_RR    = 150;
    localparam int BRADY_RR    = 300;
    localparam int IRREG_DELTA = 40;
    localparam int ASYS_LIMIT  = 1000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               sample_valid;
    logic signed [15:0] integ_in;
    logic signed [15:0] thr;
    logic               qrs_pulse;
    logic               rr_valid;
    logic [15:0]        rr_interval;
    logic [1:0]         rhythm;
    logic               asystole;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qrs_rr_controller #(
        .REFRACT    (REFRACT),
        .TACHY_RR   (TACHY_RR),
        .BRADY_RR   (BRADY_RR),
        .IRREG_DELTA(IRREG_DELTA),
        .ASYS_LIMIT (ASYS_LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sample_valid(sample_valid),
        .integ_in    (integ_in),
        .thr         (thr),
        .qrs_pulse   (qrs_pulse),
        .rr_valid    (rr_valid),
        .rr_interval (rr_interval),
        .rhythm      (rhythm),
        .asystole    (asystole)
    );

    // Reference model: detection is armed from sample index m_rearm onward.
    int          m_idx = 0;
    int          m_rearm = 0;
    int          m_cnt = 0;
    int          m_prev_rr = 0;
    int          m_irr = 0;
    bit          m_inq = 0;
    bit          m_have_prev = 0;
    bit          m_have_rr = 0;
    logic        e_qrs = 1'b0;
    logic        e_rrv = 1'b0;
    logic        e_asy = 1'b0;
    logic [15:0] e_rr = 16'd0;
    logic [1:0]  e_rhy = 2'b00;

    function automatic void model_clear_en();
        m_inq = 0; m_rearm = 0; m_cnt = 0; m_have_prev = 0; m_have_rr = 0; m_irr = 0;
        e_asy = 1'b0; e_qrs = 1'b0; e_rrv = 1'b0;
    endfunction

    function automatic void model_reset();
        model_clear_en();
        e_rr = 16'd0; e_rhy = 2'b00;
    endfunction

    function automatic void model_sample(int x, int t);
        int rr;
        int d;
        m_idx++;
        e_qrs = 1'b0;
        e_rrv = 1'b0;
        if (!m_inq && m_idx >= m_rearm && x > t) begin
            rr = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
            e_qrs = 1'b1; m_inq = 1; e_asy = 1'b0; m_cnt = 0;
            if (m_have_prev) begin
                e_rrv = 1'b1;
                if (m_have_rr) begin
                    d = rr - m_prev_rr;
                    if (d < 0) d = -d;
                    m_irr = (d > IRREG_DELTA) ? ((m_irr < 3) ? m_irr + 1 : 3) : 0;
                end
                m_prev_rr = rr; m_have_rr = 1; e_rr = 16'(rr);
                if (m_irr == 3) e_rhy = 2'b11;
                else if (rr < TACHY_RR) e_rhy = 2'b10;
                else if (rr > BRADY_RR) e_rhy = 2'b01;
                else e_rhy = 2'b00;
            end
            m_have_prev = 1;
        end else begin
            if (m_inq && x <= t) begin
                m_inq = 0;
                m_rearm = m_idx + REFRACT;
            end
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (m_cnt >= ASYS_LIMIT) e_asy = 1'b1;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic set_en(input logic v);
        @(negedge clk); en = v; sample_valid = 1'b0;
        @(posedge clk); #1;
        if (!v) model_clear_en();
    endtask

    // Occasionally inserts a non-strobed clock carrying a huge value that must be ignored.
    task automatic step(input logic signed [15:0] x, input logic signed [15:0] t);
        if ($urandom_range(3) == 0) begin
            @(negedge clk); integ_in = 16'sh7FFF; thr = 16'sh8000;
            @(posedge clk);
        end
        @(negedge clk); sample_valid = 1'b1; integ_in = x; thr = t;
        @(posedge clk); #1; sample_valid = 1'b0;
        model_sample(int'(x), int'(t));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; sample_valid = 1'b1; integ_in = 16'sd9000; thr = 16'sd8000;
        repeat (2) @(posedge clk);
        #1;
        total++; if (qrs_pulse !== 1'b0) begin bad++; $display("FAIL reset_qrs got=%b want=0", qrs_pulse); end
        total++; if (rr_valid !== 1'b0) begin bad++; $display("FAIL reset_rrv got=%b want=0", rr_valid); end
        total++; if (rr_interval !== 16'd0) begin bad++; $display("FAIL reset_rr got=%0d want=0", rr_interval); end
        total++; if (rhythm !== 2'b00) begin bad++; $display("FAIL reset_rhythm got=%b want=00", rhythm); end
        total++; if (asystole !== 1'b0) begin bad++; $display("FAIL reset_asys got=%b want=0", asystole); end
        @(negedge clk); rst_n = 1'b1; sample_valid = 1'b0;
        @(posedge clk); #1;
        model_reset();
        step(16'sd9000, 16'sd8000);
        total++; if (qrs_pulse !== 1'b1) begin bad++; $display("FAIL reset_first_qrs got=%b want=1", qrs_pulse); end
        total++; if (rr_valid !== 1'b0) begin bad++; $display("FAIL reset_first_rrv got=%b want=0", rr_valid); end
    endtask

    task automatic test_regular();
        int periods [3] = '{200, 100, 400};
        logic [1:0] want [3] = '{2'b00, 2'b10, 2'b01};
        int t, hi, lo, npulse, nrrv;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                t = 8000; hi = 9000; lo = 100;
            end else begin
                t  = int'($urandom_range(20000)) - 10000;
                hi = t + 1 + int'($urandom_range(5000));
                lo = t - int'($urandom_range(5000));
            end
            set_en(1'b0); set_en(1'b1);
            npulse = 0; nrrv = 0;
            for (int s = 0; s < 4 * periods[i]; s++) begin
                step(((s % periods[i]) < 5) ? 16'(hi) : 16'(lo), 16'(t));
                if (qrs_pulse === 1'b1) npulse++;
                if (rr_valid === 1'b1) nrrv++;
                total++; if (qrs_pulse !== e_qrs) begin bad++; $display("FAIL reg_qrs p=%0d s=%0d got=%b want=%b", periods[i], s, qrs_pulse, e_qrs); end
                total++; if (rr_valid !== e_rrv) begin bad++; $display("FAIL reg_rrv p=%0d s=%0d got=%b want=%b", periods[i], s, rr_valid, e_rrv); end
                if (e_rrv) begin
                    total++; if (rr_interval !== e_rr) begin bad++; $display("FAIL reg_rr p=%0d got=%0d want=%0d", periods[i], rr_interval, e_rr); end
                    total++; if (rhythm !== e_rhy) begin bad++; $display("FAIL reg_rhythm p=%0d got=%b want=%b", periods[i], rhythm, e_rhy); end
                end
            end
            total++; if (npulse != 4) begin bad++; $display("FAIL reg_npulse p=%0d got=%0d want=4", periods[i], npulse); end
            total++; if (nrrv != 3) begin bad++; $display("FAIL reg_nrrv p=%0d got=%0d want=3", periods[i], nrrv); end
            total++; if (rr_interval !== 16'(periods[i])) begin bad++; $display("FAIL reg_rr_final got=%0d want=%0d", rr_interval, periods[i]); end
            total++; if (rhythm !== want[i]) begin bad++; $display("FAIL reg_rhythm_final p=%0d got=%b want=%b", periods[i], rhythm, want[i]); end
        end
    endtask

    task automatic test_threshold_refract();
        set_en(1'b0); set_en(1'b1);
        step(16'sd8000, 16'sd8000);
        total++; if (qrs_pulse !== 1'b0) begin bad++; $display("FAIL thr_equal got=%b want=0", qrs_pulse); end
        step(16'sd8001, 16'sd8000);
        total++; if (qrs_pulse !== 1'b1) begin bad++; $display("FAIL thr_above got=%b want=1", qrs_pulse); end
        repeat (4) step(16'sd9000, 16'sd8000);
        step(16'sd100, 16'sd8000);
        for (int k = 1; k <= REFRACT; k++) begin
            step((k == 30 || k == REFRACT - 1 || k == REFRACT) ? 16'sd9000 : 16'sd100, 16'sd8000);
            total++; if (qrs_pulse !== e_qrs) begin bad++; $display("FAIL ref_model k=%0d got=%b want=%b", k, qrs_pulse, e_qrs); end
            if (k == 30 || k == REFRACT - 1) begin
                total++; if (qrs_pulse !== 1'b0) begin bad++; $display("FAIL ref_ignored k=%0d got=%b want=0", k, qrs_pulse); end
                total++; if (rr_valid !== 1'b0) begin bad++; $display("FAIL ref_ignored_rrv k=%0d got=%b want=0", k, rr_valid); end
            end
        end
        total++; if (qrs_pulse !== 1'b1) begin bad++; $display("FAIL ref_rearm got=%b want=1", qrs_pulse); end
        total++; if (rr_valid !== 1'b1) begin bad++; $display("FAIL ref_rearm_rrv got=%b want=1", rr_valid); end
        total++; if (rr_interval !== 16'(5 + REFRACT)) begin bad++; $display("FAIL ref_rr got=%0d want=%0d", rr_interval, 5 + REFRACT); end
        total++; if (rhythm !== 2'b10) begin bad++; $display("FAIL ref_rhythm got=%b want=10", rhythm); end
        set_en(1'b0); set_en(1'b1);
        step(-16'sd50, 16'sd100);
        total++; if (qrs_pulse !== 1'b0) begin bad++; $display("FAIL signed_below got=%b want=0", qrs_pulse); end
        step(16'sd50, -16'sd100);
        total++; if (qrs_pulse !== 1'b1) begin bad++; $display("FAIL signed_above got=%b want=1", qrs_pulse); end
    endtask

    task automatic test_irregular();
        int rrs [6] = '{200, 120, 260, 180, 200, 200};
        logic [1:0] want [6] = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00};
        int len;
        set_en(1'b0); set_en(1'b1);
        for (int j = 0; j < 7; j++) begin
            len = (j < 6) ? rrs[j] : 10;
            for (int s = 0; s < len; s++) begin
                step((s < 5) ? 16'sd9000 : 16'sd100, 16'sd8000);
                if (s == 0) begin
                    total++; if (qrs_pulse !== 1'b1) begin bad++; $display("FAIL irr_qrs beat=%0d got=%b want=1", j, qrs_pulse); end
                    total++; if (rr_valid !== (j > 0)) begin bad++; $display("FAIL irr_rrv beat=%0d got=%b want=%b", j, rr_valid, (j > 0)); end
                    if (j > 0) begin
                        total++; if (rr_interval !== 16'(rrs[j-1])) begin bad++; $display("FAIL irr_rr beat=%0d got=%0d want=%0d", j, rr_interval, rrs[j-1]); end
                        total++; if (rhythm !== want[j-1]) begin bad++; $display("FAIL irr_rhythm beat=%0d got=%b want=%b", j, rhythm, want[j-1]); end
                        total++; if (rhythm !== e_rhy) begin bad++; $display("FAIL irr_model beat=%0d got=%b want=%b", j, rhythm, e_rhy); end
                    end
                end
            end
        end
    endtask

    task automatic test_asystole();
        set_en(1'b0); set_en(1'b1);
        for (int k = 1; k <= ASYS_LIMIT; k++) begin
            step(16'sd100, 16'sd8000);
            total++; if (asystole !== e_asy) begin bad++; $display("FAIL asys_model k=%0d got=%b want=%b", k, asystole, e_asy); end
            if (k == ASYS_LIMIT - 1) begin
                total++; if (asystole !== 1'b0) begin bad++; $display("FAIL asys_early got=%b want=0", asystole); end
            end
        end
        total++; if (asystole !== 1'b1) begin bad++; $display("FAIL asys_set got=%b want=1", asystole); end
        step(16'sd9000, 16'sd8000);
        total++; if (qrs_pulse !== 1'b1) begin bad++; $display("FAIL asys_qrs got=%b want=1", qrs_pulse); end
        total++; if (asystole !== 1'b0) begin bad++; $display("FAIL asys_clear got=%b want=0", asystole); end
        repeat (4) step(16'sd9000, 16'sd8000);
        repeat (95) step(16'sd100, 16'sd8000);
        step(16'sd9000, 16'sd8000);
        total++; if (rr_interval !== 16'd100) begin bad++; $display("FAIL asys_rr got=%0d want=100", rr_interval); end
        repeat (4) step(16'sd9000, 16'sd8000);
        repeat (11) step(16'sd100, 16'sd8000);
        set_en(1'b0);
        total++; if (rhythm !== 2'b10) begin bad++; $display("FAIL hold_rhythm got=%b want=10", rhythm); end
        total++; if (rr_interval !== 16'd100) begin bad++; $display("FAIL hold_rr got=%0d want=100", rr_interval); end
        total++; if (qrs_pulse !== 1'b0) begin bad++; $display("FAIL hold_qrs got=%b want=0", qrs_pulse); end
        set_en(1'b1);
        step(16'sd9000, 16'sd8000);
        total++; if (qrs_pulse !== 1'b1) begin bad++; $display("FAIL reen_qrs got=%b want=1", qrs_pulse); end
        total++; if (rr_valid !== 1'b0) begin bad++; $display("FAIL reen_rrv got=%b want=0", rr_valid); end
        repeat (4) step(16'sd9000, 16'sd8000);
        repeat (1 + REFRACT) step(16'sd100, 16'sd8000);
        @(negedge clk); en = 1'b0; sample_valid = 1'b1; integ_in = 16'sd9000; thr = 16'sd8000;
        @(posedge clk); #1; sample_valid = 1'b0;
        model_clear_en();
        total++; if (qrs_pulse !== 1'b0) begin bad++; $display("FAIL enfall_qrs got=%b want=0", qrs_pulse); end
        set_en(1'b1);
        step(16'sd9000, 16'sd8000);
        total++; if (qrs_pulse !== 1'b1) begin bad++; $display("FAIL enfall_next_qrs got=%b want=1", qrs_pulse); end
        total++; if (rr_valid !== 1'b0) begin bad++; $display("FAIL enfall_next_rrv got=%b want=0", rr_valid); end
    endtask

    task automatic test_reset_abort();
        set_en(1'b0); set_en(1'b1);
        step(16'sd9000, 16'sd8000);
        repeat (4) step(16'sd9000, 16'sd8000);
        repeat (95) step(16'sd100, 16'sd8000);
        step(16'sd9000, 16'sd8000);
        step(16'sd9000, 16'sd8000);
        do_reset();
        step(16'sd9000, 16'sd8000);
        total++; if (qrs_pulse !== 1'b1) begin bad++; $display("FAIL abort_peak_qrs got=%b want=1", qrs_pulse); end
        total++; if (rr_valid !== 1'b0) begin bad++; $display("FAIL abort_peak_rrv got=%b want=0", rr_valid); end
        total++; if (rr_interval !== 16'd0) begin bad++; $display("FAIL abort_rr got=%0d want=0", rr_interval); end
        repeat (4) step(16'sd9000, 16'sd8000);
        repeat (6) step(16'sd100, 16'sd8000);
        do_reset();
        step(16'sd9000, 16'sd8000);
        total++; if (qrs_pulse !== 1'b1) begin bad++; $display("FAIL abort_ref_qrs got=%b want=1", qrs_pulse); end
        total++; if (rr_valid !== 1'b0) begin bad++; $display("FAIL abort_ref_rrv got=%b want=0", rr_valid); end
    endtask

    task automatic test_random();
        int t, per, blen, x, r;
        for (int seg = 0; seg < 24; seg++) begin
            r = int'($urandom_range(19));
            if (r == 0) do_reset();
            else if (r < 3) begin set_en(1'b0); set_en(1'b1); end
            t    = int'($urandom_range(20000)) - 10000;
            per  = 60 + int'($urandom_range(400));
            blen = 1 + int'($urandom_range(7));
            for (int s = 0; s < per; s++) begin
                if (s < blen || $urandom_range(49) == 0) x = t + 1 + int'($urandom_range(3000));
                else x = t - int'($urandom_range(3000));
                step(16'(x), 16'(t));
                total++; if (qrs_pulse !== e_qrs) begin bad++; $display("FAIL rnd_qrs idx=%0d got=%b want=%b", m_idx, qrs_pulse, e_qrs); end
                total++; if (rr_valid !== e_rrv) begin bad++; $display("FAIL rnd_rrv idx=%0d got=%b want=%b", m_idx, rr_valid, e_rrv); end
                total++; if (rr_interval !== e_rr) begin bad++; $display("FAIL rnd_rr idx=%0d got=%0d want=%0d", m_idx, rr_interval, e_rr); end
                total++; if (rhythm !== e_rhy) begin bad++; $display("FAIL rnd_rhythm idx=%0d got=%b want=%b", m_idx, rhythm, e_rhy); end
                total++; if (asystole !== e_asy) begin bad++; $display("FAIL rnd_asys idx=%0d got=%b want=%b", m_idx, asystole, e_asy); end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; sample_valid = 1'b0; integ_in = 16'sd0; thr = 16'sd0;
        test_reset();
        test_regular();
        test_threshold_refract();
        test_irregular();
        test_asystole();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
